instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 6 +
 rtl/instr_fetch_if.sv | 22 ++
 rtl/fetch_buf.sv | 36 +++
 rtl/instr_fetch.sv | 68 ++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM state type and constants for the instruction fetch unit
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;
    localparam int BUF_DEPTH = 2;
    localparam logic [127:0] HALT_OPCODE = '1;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: memory read port, redirect request and decoder handshake of the fetch unit
interface instr_fetch_if #(parameter int width = 32, parameter int depth = 32);
    localparam int AW = $clog2(depth);
    logic             mem_rd_en;
    logic [AW-1:0]    mem_addr;
    logic [width-1:0] mem_rdata;
    logic             redirect_valid;
    logic [AW-1:0]    redirect_pc;
    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] out_instr;
    logic [AW-1:0]    out_pc;
    logic             halted;
    modport master (
        output mem_rd_en, mem_addr, out_valid, out_instr, out_pc, halted,
        input  mem_rdata, redirect_valid, redirect_pc, out_ready
    );
    modport slave (
        input  mem_rd_en, mem_addr, out_valid, out_instr, out_pc, halted,
        output mem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_buf.sv
// fetch_buf: 2-entry FIFO holding {pc, instr} pairs between memory and decoder
import fetch_pkg::*;
module fetch_buf #(parameter int dw = 37) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [dw-1:0] din,
    output logic [dw-1:0] dout,
    output logic [1:0]    count
);
    logic [dw-1:0] mem [BUF_DEPTH];
    logic          rd, wr;
    // pointers and occupancy; flush empties the buffer regardless of push/pop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd    <= 1'b0;
            wr    <= 1'b0;
            count <= 2'd0;
        end else if (flush) begin
            rd    <= 1'b0;
            wr    <= 1'b0;
            count <= 2'd0;
        end else begin
            wr    <= wr ^ push;
            rd    <= rd ^ pop;
            count <= count + 2'(push) - 2'(pop);
        end
    end
    // entry storage; contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr] <= din;
    end
    assign dout = mem[rd];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC/FSM fetch front end with 2-entry buffer; INSTR_FETCH_HALT_EN compiles in halt-opcode detection
import fetch_pkg::*;
module instr_fetch #(parameter int width = 32, parameter int depth = 32) (
    input logic          clk,
    input logic          reset,
    instr_fetch_if.master bus
);
    localparam int AW = $clog2(depth);
    state_t              state, nxt;
    logic [AW-1:0]       pc, fl_pc;
    logic                fl, redir, valid, pop, push, issue, halt_hit;
    logic [1:0]          cnt;
    logic [2:0]          occ;
    logic [AW+width-1:0] head;
    assign redir = bus.redirect_valid && state != IDLE;
    assign valid = cnt != 2'd0;
    assign pop   = valid && bus.out_ready;
    assign push  = fl && !redir;
    assign occ   = 3'(cnt) + 3'(fl);
`ifdef INSTR_FETCH_HALT_EN
    assign halt_hit = fl && !redir && bus.mem_rdata == HALT_OPCODE[width-1:0];
`else
    assign halt_hit = 1'b0;
`endif
    assign issue = state == FETCH && !halt_hit && occ < (pop ? 3'd3 : 3'd2);
    fetch_buf #(.dw(AW + width)) u_buf (
        .clk(clk), .reset(reset), .flush(redir), .push(push), .pop(pop),
        .din({fl_pc, bus.mem_rdata}), .dout(head), .count(cnt)
    );
    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= nxt;
    end
    // next state: leave IDLE immediately, halt on opcode capture, resume on redirect
    always_comb begin
        nxt = state == IDLE  ? FETCH :
              state == FETCH ? (halt_hit ? HALT : FETCH) :
              (redir ? FETCH : HALT);
    end
    // outputs: read strobe from PC, head entry shown only while valid
    always_comb begin
        bus.mem_rd_en = issue;
        bus.mem_addr  = pc;
        bus.out_valid = valid;
        bus.out_instr = valid ? head[width-1:0] : '0;
        bus.out_pc    = valid ? head[width +: AW] : '0;
`ifdef INSTR_FETCH_HALT_EN
        bus.halted    = state == HALT;
`else
        bus.halted    = 1'b0;
`endif
    end
    // PC and in-flight tracking; a read issued on a redirect edge is dropped
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc    <= '0;
            fl    <= 1'b0;
            fl_pc <= '0;
        end else begin
            fl    <= issue && !redir;
            fl_pc <= pc;
            pc    <= redir ? bus.redirect_pc :
                     !issue ? pc :
                     pc == AW'(depth - 1) ? '0 : pc + 1'b1;
        end
    end
endmodule
